// File: rtl/fixed_divider.sv
// -----------------------------------------------------------------------------
// fixed_divider
//
// Signed fixed-point divider, c = trunc_toward_zero((a << fractional_size) / b),
// built as a sequential restoring divider that produces one quotient bit per
// clock, MSB first. There is no multiplier or divider in the datapath: it uses
// only shift, subtract, compare and mux.
//
// Handshake: in_ready is high only in IDLE and out_valid only in DONE. A result
// stays stable until out_valid && out_ready.
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous, active-high reset
//   in_valid     a/b valid this cycle (sampled only in IDLE)
//   in_ready     block can accept a new operand pair
//   a, b         signed fixed-point dividend / divisor
//   out_valid    c and flags valid
//   out_ready    consumer accepts the result (sampled only in DONE)
//   c            signed fixed-point quotient
//   div_by_zero  b was zero; c is +max when a >= 0, -max-1 when a < 0
//   overflow     the true quotient does not fit in operand_size bits
//
// Configuration macro
//   FIXED_DIVIDER_SATURATE_EN  defined:   c clamps to +max / -max-1 on overflow
//                              undefined: c wraps to the low operand_size bits
// -----------------------------------------------------------------------------
module fixed_divider #(
  parameter int fractional_size = 12,
  parameter int operand_size    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [operand_size-1:0] a,
  input  logic [operand_size-1:0] b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [operand_size-1:0] c,
  output logic                    div_by_zero,
  output logic                    overflow
);

  localparam int ITER  = operand_size + fractional_size;
  localparam int CNT_W = $clog2(ITER);

  localparam logic [CNT_W-1:0]        CNT_START = CNT_W'(ITER - 1);
  localparam logic [operand_size-1:0] MAX_C     = {1'b0, {(operand_size-1){1'b1}}};
  localparam logic [operand_size-1:0] MIN_C     = {1'b1, {(operand_size-1){1'b0}}};
  // Largest quotient magnitudes that still fit, for each result sign.
  localparam logic [ITER-1:0] POS_LIMIT = {{fractional_size{1'b0}}, MAX_C};
  localparam logic [ITER-1:0] NEG_LIMIT = {{fractional_size{1'b0}}, MIN_C};

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    DONE
  } state_t;

  state_t                  state_reg;
  logic [CNT_W-1:0]        count_reg;
  // Shared dividend/quotient register: dividend bits leave at the MSB while
  // quotient bits enter at the LSB, so after ITER steps it holds |quotient|.
  logic [ITER-1:0]         dq_reg;
  logic [operand_size:0]   rem_reg;
  logic [operand_size-1:0] b_mag_reg;
  logic                    sign_reg;
  logic [operand_size-1:0] c_reg;
  logic                    dbz_reg;
  logic                    ovf_reg;

  // Operand magnitudes. The most negative value maps onto 2^(operand_size-1),
  // which is still representable as an unsigned magnitude.
  logic [operand_size-1:0] a_mag;
  logic [operand_size-1:0] b_mag;

  assign a_mag = a[operand_size-1] ? -a : a;
  assign b_mag = b[operand_size-1] ? -b : b;

  // One restoring-division step.
  logic [operand_size:0]   rem_shift;
  logic [operand_size:0]   rem_trial;
  logic                    q_bit;
  logic [operand_size:0]   rem_next;
  logic [ITER-1:0]         dq_next;

  always_comb begin
    rem_shift = {rem_reg[operand_size-1:0], dq_reg[ITER-1]};
    rem_trial = rem_shift - {1'b0, b_mag_reg};
    q_bit     = (rem_shift >= {1'b0, b_mag_reg});
    rem_next  = q_bit ? rem_trial : rem_shift;
    dq_next   = {dq_reg[ITER-2:0], q_bit};
  end

  // Final signed result, evaluated on the step that completes iteration 0.
  logic [operand_size-1:0] q_low;
  logic [operand_size-1:0] c_next;
  logic                    ovf_next;

  always_comb begin
    q_low    = dq_next[operand_size-1:0];
    ovf_next = sign_reg ? (dq_next > NEG_LIMIT) : (dq_next > POS_LIMIT);
    // Negating the low bits equals the low bits of the negated magnitude,
    // and a zero magnitude stays zero.
    c_next   = sign_reg ? -q_low : q_low;
`ifdef FIXED_DIVIDER_SATURATE_EN
    if (ovf_next) begin
      c_next = sign_reg ? MIN_C : MAX_C;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
      dq_reg    <= '0;
      rem_reg   <= '0;
      b_mag_reg <= '0;
      sign_reg  <= 1'b0;
      c_reg     <= '0;
      dbz_reg   <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            dq_reg    <= {a_mag, {fractional_size{1'b0}}};
            rem_reg   <= '0;
            b_mag_reg <= b_mag;
            sign_reg  <= a[operand_size-1] ^ b[operand_size-1];
            if (b == '0) begin
              // Substitute result is available immediately.
              state_reg <= DONE;
              c_reg     <= a[operand_size-1] ? MIN_C : MAX_C;
              dbz_reg   <= 1'b1;
              ovf_reg   <= 1'b0;
            end else begin
              state_reg <= DIVIDE;
              count_reg <= CNT_START;
            end
          end
        end

        DIVIDE: begin
          rem_reg <= rem_next;
          dq_reg  <= dq_next;
          if (count_reg == '0) begin
            state_reg <= DONE;
            c_reg     <= c_next;
            ovf_reg   <= ovf_next;
            dbz_reg   <= 1'b0;
          end else begin
            count_reg <= count_reg - CNT_W'(1);
          end
        end

        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
            dbz_reg   <= 1'b0;
            ovf_reg   <= 1'b0;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = (state_reg == IDLE);
  assign out_valid   = (state_reg == DONE);
  assign c           = c_reg;
  assign div_by_zero = dbz_reg;
  assign overflow    = ovf_reg;

endmodule

// File: tb/tb_fixed_divider.sv
// -----------------------------------------------------------------------------
// tb_fixed_divider
//
// Self-checking bench for fixed_divider at the default 32/12 configuration.
// The reference model computes (a * 2^12) / b with 64-bit signed arithmetic
// and derives the expected flags and the wrapped or clamped result from that.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fixed_divider;

  localparam int FRAC = 12;
  localparam int OPW  = 32;
  localparam int ITER = OPW + FRAC;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [OPW-1:0]  a;
  logic [OPW-1:0]  b;
  logic            out_valid;
  logic            out_ready;
  logic [OPW-1:0]  c;
  logic            div_by_zero;
  logic            overflow;

  int checks = 0;
  int errors = 0;

  fixed_divider #(
    .fractional_size(FRAC),
    .operand_size   (OPW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .c          (c),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: exact quotient with truncation toward zero, then range check.
  task automatic model(input logic [OPW-1:0] ai, input logic [OPW-1:0] bi,
                       output logic [OPW-1:0] ce, output logic dz, output logic ov);
    longint sa;
    longint sb;
    longint q;
    sa = longint'($signed(ai));
    sb = longint'($signed(bi));
    if (bi == '0) begin
      dz = 1'b1;
      ov = 1'b0;
      ce = ai[OPW-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      dz = 1'b0;
      q  = (sa * (longint'(1) << FRAC)) / sb;
      ov = (q > 64'sd2147483647) || (q < -64'sd2147483648);
      ce = q[OPW-1:0];
`ifdef FIXED_DIVIDER_SATURATE_EN
      if (ov) ce = (q < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    end
  endtask

  // One complete transaction. 'junk' drives random in_valid/a/b/out_ready
  // while the divider is busy; all of it must be ignored.
  task automatic run_op(input logic [OPW-1:0] ai, input logic [OPW-1:0] bi,
                        input int hold, input bit junk);
    logic [OPW-1:0] ce;
    logic dz;
    logic ov;
    int lat;
    model(ai, bi, ce, dz, ov);
    @(negedge clk);
    check_value("in_ready_idle", in_ready, 1);
    a = ai;
    b = bi;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      check_value("in_ready_busy", in_ready, 0);
      if (junk) begin
        in_valid  = 1'($urandom_range(0, 1));
        a         = $urandom;
        b         = $urandom;
        out_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      lat++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_value("latency", lat, (bi == '0) ? 0 : ITER);
    check_value("c", c, ce);
    check_value("div_by_zero", div_by_zero, dz);
    check_value("overflow", overflow, ov);
    check_value("in_ready_done", in_ready, 0);
    $display("op a=0x%08h b=0x%08h -> c=0x%08h dbz=%0b ovf=%0b lat=%0d (exp c=0x%08h dbz=%0b ovf=%0b)",
             ai, bi, c, div_by_zero, overflow, lat, ce, dz, ov);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_value("hold_out_valid", out_valid, 1);
      check_value("hold_c", c, ce);
      check_value("hold_dbz", div_by_zero, dz);
      check_value("hold_ovf", overflow, ov);
      check_value("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_value("release_in_ready", in_ready, 1);
    check_value("release_out_valid", out_valid, 0);
    check_value("release_dbz", div_by_zero, 0);
    check_value("release_ovf", overflow, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_value({tag, "_in_ready"}, in_ready, 1);
    check_value({tag, "_out_valid"}, out_valid, 0);
    check_value({tag, "_c"}, c, 0);
    check_value({tag, "_dbz"}, div_by_zero, 0);
    check_value({tag, "_ovf"}, overflow, 0);
  endtask

  initial begin
    logic [OPW-1:0] ra;
    logic [OPW-1:0] rb;
    bit seen_valid;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Directed vectors.
    run_op(32'h0000_3000, 32'h0000_2000, 0, 1'b0);
    run_op(32'hFFFF_D000, 32'h0000_2000, 0, 1'b0);
    run_op(32'h0000_1000, 32'h0000_3000, 0, 1'b0);
    run_op(32'hFFFF_F000, 32'h0000_0000, 0, 1'b0);
    run_op(32'h0000_0000, 32'h0000_0000, 0, 1'b0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 0, 1'b0);
    run_op(32'h8000_0000, 32'h0000_1000, 0, 1'b0);   // exactly -2^31, no overflow
    run_op(32'h8000_0000, 32'hFFFF_F000, 0, 1'b0);   // +2^31, overflow
    run_op(32'h0000_0000, 32'hFFFF_E000, 0, 1'b0);   // -0 result
    run_op(32'h0000_3000, 32'h0000_2000, 10, 1'b0);  // long hold in DONE

    // Reset in the middle of a division aborts it.
    @(negedge clk);
    a = 32'h0000_3000;
    b = 32'h0000_2000;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("abort");
    rst = 1'b0;
    seen_valid = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    check_value("abort_no_result", seen_valid, 0);
    $display("abort: reset during divide, result presented=%0b", seen_valid);
    run_op(32'h0000_6000, 32'h0000_2000, 0, 1'b0);

    // Randomised operands, with busy-time junk on the inputs.
    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = '0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = -32'($urandom_range(1, 4096));
        3:       rb = 32'($urandom_range(0, 32'h000F_FFFF));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = ra >>> $urandom_range(8, 28);
      run_op(ra, rb, $urandom_range(0, 3), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
